// File: rtl/axicb_pkg.sv
// Shared constants and width helpers for the crossbar switch blocks.
//   PRI_W  : width of one master's priority level (0 lowest, 3 highest)
//   idx_w  : bits needed to index n items (at least 1)
//   cnt_w  : bits needed to count 0..n inclusive, for power-of-2 n
package axicb_pkg;

  localparam int unsigned PRI_W = 2;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/axicb_pri_rr_arbiter.sv
// Priority + round-robin arbiter.
// The highest priority level present among the active requests wins. Ties
// at that level go round-robin, with the search starting at ptr + 1.
//   req       : request vector
//   pri       : packed REQ_NB x PRI_W priority levels
//   ptr       : index of the last granted requester
//   grant     : one-hot grant (zero when nothing requests)
//   grant_idx : binary index of the granted requester
//   grant_vld : at least one request present
module axicb_pri_rr_arbiter
  import axicb_pkg::*;
#(
  parameter int unsigned REQ_NB = 4,
  parameter int unsigned IDX_W  = 2
) (
  input  logic [REQ_NB-1:0]       req,
  input  logic [REQ_NB*PRI_W-1:0] pri,
  input  logic [IDX_W-1:0]        ptr,
  output logic [REQ_NB-1:0]       grant,
  output logic [IDX_W-1:0]        grant_idx,
  output logic                    grant_vld
);

  logic [PRI_W-1:0] top_pri;
  int unsigned      j;

  always_comb begin
    top_pri   = '0;
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    j         = 0;
    for (int unsigned i = 0; i < REQ_NB; i++) begin
      if (req[i] && (pri[i*PRI_W +: PRI_W] > top_pri))
        top_pri = pri[i*PRI_W +: PRI_W];
    end
    // Walk the ring once, starting just after the last winner.
    for (int unsigned k = 1; k <= REQ_NB; k++) begin
      j = (32'(ptr) + k) % REQ_NB;
      if (!grant_vld && req[j] && (pri[j*PRI_W +: PRI_W] == top_pri)) begin
        grant_vld = 1'b1;
        grant_idx = IDX_W'(j);
        grant[j]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axicb_slv_wr_switch.sv
// Write-path slave switch: merges MST_NB masters' AW/W traffic onto one
// slave port and routes B completions back by ID.
//   aclk, aresetn            : clock, asynchronous active-low reset
//   i_aw* / i_w* / i_b*      : per-master AW, W and B channels
//   o_aw* / o_w* / o_b*      : slave-side AW, W and B channels
//   o_ostd_cnt               : granted writes whose last W beat is not yet sent
//   o_decerr                 : sticky, a B response matched no master
module axicb_slv_wr_switch
  import axicb_pkg::*;
#(
  parameter int unsigned                   MST_NB       = 4,
  parameter int unsigned                   AXI_ID_W     = 8,
  parameter int unsigned                   AWCH_W       = 8,
  parameter int unsigned                   WCH_W        = 8,
  parameter int unsigned                   BCH_W        = 8,
  parameter int unsigned                   OSTDREQ_NUM  = 4,
  parameter logic [MST_NB*AXI_ID_W-1:0]    MST_ID_MASK  = {8'h30, 8'h20, 8'h10, 8'h00},
  parameter logic [MST_NB*PRI_W-1:0]       MST_PRIORITY = '0
) (
  input  logic                               aclk,
  input  logic                               aresetn,
  input  logic [MST_NB-1:0]                  i_awvalid,
  output logic [MST_NB-1:0]                  i_awready,
  input  logic [MST_NB*AWCH_W-1:0]           i_awch,
  input  logic [MST_NB-1:0]                  i_wvalid,
  output logic [MST_NB-1:0]                  i_wready,
  input  logic [MST_NB-1:0]                  i_wlast,
  input  logic [MST_NB*WCH_W-1:0]            i_wch,
  output logic [MST_NB-1:0]                  i_bvalid,
  input  logic [MST_NB-1:0]                  i_bready,
  output logic [BCH_W-1:0]                   i_bch,
  output logic                               o_awvalid,
  input  logic                               o_awready,
  output logic [AWCH_W-1:0]                  o_awch,
  output logic                               o_wvalid,
  input  logic                               o_wready,
  output logic                               o_wlast,
  output logic [WCH_W-1:0]                   o_wch,
  input  logic                               o_bvalid,
  output logic                               o_bready,
  input  logic [BCH_W-1:0]                   o_bch,
  output logic [$clog2(OSTDREQ_NUM):0]       o_ostd_cnt,
  output logic                               o_decerr
);

  localparam int unsigned IDX_W = idx_w(MST_NB);
  localparam int unsigned PTR_W = $clog2(OSTDREQ_NUM);
  localparam int unsigned CNT_W = cnt_w(OSTDREQ_NUM);

  logic [IDX_W-1:0]  rr_ptr;
  logic [MST_NB-1:0] arb_grant;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_vld;
  logic              grant_en;

  logic [IDX_W-1:0]  q_mem [OSTDREQ_NUM];
  logic [PTR_W-1:0]  q_wr;
  logic [PTR_W-1:0]  q_rd;
  logic [CNT_W-1:0]  q_cnt;
  logic              q_full;
  logic              q_empty;
  logic              pop;
  logic [IDX_W-1:0]  head;

  logic [AXI_ID_W-1:0] id_sel;
  logic [MST_NB-1:0]   bmatch;

  axicb_pri_rr_arbiter #(
    .REQ_NB (MST_NB),
    .IDX_W  (IDX_W)
  ) u_arb (
    .req       (i_awvalid),
    .pri       (MST_PRIORITY),
    .ptr       (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .grant_vld (arb_vld)
  );

  // ---------------- AW arbitration and output register ----------------
  assign q_full  = (q_cnt == CNT_W'(OSTDREQ_NUM));
  assign q_empty = (q_cnt == '0);
  // aresetn gates the combinational ready so no handshake completes in reset.
  assign grant_en  = aresetn && arb_vld && (!o_awvalid || o_awready) && !q_full;
  assign i_awready = grant_en ? arb_grant : '0;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      o_awvalid <= 1'b0;
      o_awch    <= '0;
      rr_ptr    <= IDX_W'(MST_NB - 1);
    end else if (grant_en) begin
      o_awvalid <= 1'b1;
      o_awch    <= i_awch[arb_idx*AWCH_W +: AWCH_W];
      rr_ptr    <= arb_idx;
    end else if (o_awready) begin
      o_awvalid <= 1'b0;
    end
  end

  // ---------------- Ordering queue of granted masters ----------------
  assign head = q_mem[q_rd];
  assign pop  = o_wvalid && o_wready && o_wlast;

  always_ff @(posedge aclk) begin
    if (grant_en)
      q_mem[q_wr] <= arb_idx;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      q_wr  <= '0;
      q_rd  <= '0;
      q_cnt <= '0;
    end else begin
      if (grant_en) q_wr <= q_wr + PTR_W'(1);
      if (pop)      q_rd <= q_rd + PTR_W'(1);
      case ({grant_en, pop})
        2'b10:   q_cnt <= q_cnt + CNT_W'(1);
        2'b01:   q_cnt <= q_cnt - CNT_W'(1);
        default: q_cnt <= q_cnt;
      endcase
    end
  end

  assign o_ostd_cnt = q_cnt;

  // ---------------- W path: the queue head owns the slave W channel ----------------
  always_comb begin
    i_wready = '0;
    o_wvalid = !q_empty && i_wvalid[head];
    o_wlast  = i_wlast[head];
    o_wch    = i_wch[head*WCH_W +: WCH_W];
    if (!q_empty && o_wready)
      i_wready[head] = 1'b1;
  end

  // ---------------- B path: route by ID tag ----------------
  always_comb begin
    id_sel = '0;
    bmatch = '0;
    for (int unsigned m = 0; m < MST_NB; m++)
      id_sel = id_sel | MST_ID_MASK[m*AXI_ID_W +: AXI_ID_W];
    for (int unsigned m = 0; m < MST_NB; m++)
      bmatch[m] = ((o_bch[AXI_ID_W-1:0] & id_sel) == MST_ID_MASK[m*AXI_ID_W +: AXI_ID_W]);
  end

  assign i_bch    = o_bch;
  assign i_bvalid = o_bvalid ? bmatch : '0;
  // An unmatched response is swallowed so the slave never stalls on it.
  assign o_bready = (|bmatch) ? |(bmatch & i_bready) : (aresetn && o_bvalid);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)
      o_decerr <= 1'b0;
    else if (o_bvalid && !(|bmatch))
      o_decerr <= 1'b1;
  end

endmodule

// File: tb/tb_axicb_slv_wr_switch.sv
module tb_axicb_slv_wr_switch;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [3:0]  i_awvalid, i_wvalid, i_wlast, i_bready;
  logic [31:0] i_awch, i_wch;
  logic        o_awready, o_wready, o_bvalid;
  logic [7:0]  o_bch;

  // dut1: default masks, flat priority
  logic [3:0] i_awready1, i_wready1, i_bvalid1;
  logic [7:0] i_bch1, o_awch1, o_wch1;
  logic       o_awvalid1, o_wvalid1, o_wlast1, o_bready1, o_decerr1;
  logic [2:0] o_ostd_cnt1;
  // dut2: master0 tag 'h01, master2 priority 3
  logic [3:0] i_awready2, i_wready2, i_bvalid2;
  logic [7:0] i_bch2, o_awch2, o_wch2;
  logic       o_awvalid2, o_wvalid2, o_wlast2, o_bready2, o_decerr2;
  logic [2:0] o_ostd_cnt2;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] sb [$];
  logic mon_sel = 1'b0;

  always #5 aclk = ~aclk;

  axicb_slv_wr_switch dut1 (
    .aclk(aclk), .aresetn(aresetn),
    .i_awvalid(i_awvalid), .i_awready(i_awready1), .i_awch(i_awch),
    .i_wvalid(i_wvalid), .i_wready(i_wready1), .i_wlast(i_wlast), .i_wch(i_wch),
    .i_bvalid(i_bvalid1), .i_bready(i_bready), .i_bch(i_bch1),
    .o_awvalid(o_awvalid1), .o_awready(o_awready), .o_awch(o_awch1),
    .o_wvalid(o_wvalid1), .o_wready(o_wready), .o_wlast(o_wlast1), .o_wch(o_wch1),
    .o_bvalid(o_bvalid), .o_bready(o_bready1), .o_bch(o_bch),
    .o_ostd_cnt(o_ostd_cnt1), .o_decerr(o_decerr1)
  );

  axicb_slv_wr_switch #(
    .MST_ID_MASK  ({8'h30, 8'h20, 8'h10, 8'h01}),
    .MST_PRIORITY (8'b00_11_00_00)
  ) dut2 (
    .aclk(aclk), .aresetn(aresetn),
    .i_awvalid(i_awvalid), .i_awready(i_awready2), .i_awch(i_awch),
    .i_wvalid(i_wvalid), .i_wready(i_wready2), .i_wlast(i_wlast), .i_wch(i_wch),
    .i_bvalid(i_bvalid2), .i_bready(i_bready), .i_bch(i_bch2),
    .o_awvalid(o_awvalid2), .o_awready(o_awready), .o_awch(o_awch2),
    .o_wvalid(o_wvalid2), .o_wready(o_wready), .o_wlast(o_wlast2), .o_wch(o_wch2),
    .o_bvalid(o_bvalid), .o_bready(o_bready2), .o_bch(o_bch),
    .o_ostd_cnt(o_ostd_cnt2), .o_decerr(o_decerr2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset;
    aresetn   = 1'b0;
    i_awvalid = '0; i_wvalid = '0; i_wlast = '0; i_bready = '0;
    i_wch     = '0; o_awready = 1'b0; o_wready = 1'b0;
    o_bvalid  = 1'b0; o_bch = '0;
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
  endtask

  // AW scoreboard: payloads pushed when stimulus is driven, popped on handshake.
  always @(negedge aclk) begin
    if (aresetn) begin
      if ((!mon_sel && o_awvalid1 && o_awready) || (mon_sel && o_awvalid2 && o_awready)) begin
        if (sb.size() == 0)
          chk("aw_unexpected", 32'(mon_sel ? o_awch2 : o_awch1), 32'hFFFF_FFFF);
        else
          chk("aw_payload", 32'(mon_sel ? o_awch2 : o_awch1), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] bid;
    logic [3:0] bready;
    logic [3:0] exp_bvalid1;
    logic       exp_bready1;
    logic [3:0] exp_bvalid2;
    logic       exp_bready2;
    logic       exp_decerr2;
  } bvec_t;

  bvec_t bv [6];

  initial begin
    // dut1 tags 00/10/20/30 (SEL 30); dut2 tags 01/10/20/30 (SEL 31)
    bv[0] = '{8'h20, 4'b1111, 4'b0100, 1'b1, 4'b0100, 1'b1, 1'b0};
    bv[1] = '{8'h45, 4'b1111, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b0};
    bv[2] = '{8'h20, 4'b1011, 4'b0100, 1'b0, 4'b0100, 1'b0, 1'b0};
    bv[3] = '{8'h05, 4'b1111, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b0};
    bv[4] = '{8'h00, 4'b1111, 4'b0001, 1'b1, 4'b0000, 1'b1, 1'b0};
    bv[5] = '{8'h3C, 4'b0111, 4'b1000, 1'b0, 4'b1000, 1'b0, 1'b1};

    i_awch = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

    // ---- reset state ----
    do_reset();
    aresetn = 1'b0;
    #1;
    chk("rst_awvalid", 32'(o_awvalid1), 0);
    chk("rst_wvalid",  32'(o_wvalid1), 0);
    chk("rst_ostd",    32'(o_ostd_cnt1), 0);
    chk("rst_decerr",  32'(o_decerr1), 0);
    chk("rst_bready",  32'(o_bready1), 0);
    chk("rst_awready", 32'(i_awready1), 0);
    do_reset();

    // ---- flat priority round robin, then full queue ----
    mon_sel   = 1'b0;
    o_awready = 1'b1;
    i_awvalid = 4'b1111;
    for (int k = 0; k < 4; k++) sb.push_back(8'hA0 + 8'(k));
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_grant", 32'(i_awready1), 32'(4'b0001 << k));
      tick();
      i_awvalid[k] = 1'b0;
      #1;
      chk("rr_awvalid", 32'(o_awvalid1), 1);
    end
    chk("full_ostd", 32'(o_ostd_cnt1), 4);
    i_awvalid = 4'b0001;
    #1;
    chk("full_no_grant", 32'(i_awready1), 0);
    tick();
    chk("full_no_grant2", 32'(i_awready1), 0);
    chk("full_ostd2", 32'(o_ostd_cnt1), 4);
    i_wvalid = 4'b0001; i_wlast = 4'b0001; i_wch = 32'h0000_0055; o_wready = 1'b1;
    #1;
    chk("pop_wvalid", 32'(o_wvalid1), 1);
    chk("pop_wch", 32'(o_wch1), 32'h55);
    chk("pop_wready", 32'(i_wready1), 32'b0001);
    chk("full_pop_no_grant", 32'(i_awready1), 0);
    sb.push_back(8'hA0);
    tick();
    i_wvalid = '0; i_wlast = '0;
    #1;
    chk("after_pop_ostd", 32'(o_ostd_cnt1), 3);
    chk("after_pop_grant", 32'(i_awready1), 32'b0001);
    tick();
    i_awvalid = '0;
    #1;
    chk("refill_ostd", 32'(o_ostd_cnt1), 4);
    tick();
    chk("sb_drained1", sb.size(), 0);

    // ---- W ordering, AW backpressure ----
    do_reset();
    o_wready = 1'b1;
    i_wvalid = 4'b0010; i_wch = 32'h0000_1000;
    #1;
    chk("empty_wready", 32'(i_wready1), 0);
    chk("empty_wvalid", 32'(o_wvalid1), 0);
    i_awvalid = 4'b0011;
    sb.push_back(8'hA0); sb.push_back(8'hA1);
    #1;
    chk("bp_grant0", 32'(i_awready1), 32'b0001);
    tick();
    i_awvalid = 4'b0010;
    #1;
    chk("bp_hold_valid", 32'(o_awvalid1), 1);
    chk("bp_hold_payload", 32'(o_awch1), 32'hA0);
    chk("bp_blocked", 32'(i_awready1), 0);
    chk("head0_wready", 32'(i_wready1), 32'b0001);
    chk("head0_wvalid", 32'(o_wvalid1), 0);
    tick();
    chk("bp_hold_payload2", 32'(o_awch1), 32'hA0);
    chk("bp_blocked2", 32'(i_awready1), 0);
    o_awready = 1'b1;
    #1;
    chk("bp_release_grant1", 32'(i_awready1), 32'b0010);
    tick();
    i_awvalid = '0;
    #1;
    chk("w_ostd2", 32'(o_ostd_cnt1), 2);
    i_wvalid = 4'b0011; i_wlast = 4'b0001; i_wch = 32'h0000_100F;
    #1;
    chk("w0_wvalid", 32'(o_wvalid1), 1);
    chk("w0_wch", 32'(o_wch1), 32'h0F);
    chk("w0_wready", 32'(i_wready1), 32'b0001);
    tick();
    for (int b = 0; b < 4; b++) begin
      i_wvalid = 4'b0010;
      i_wlast  = (b == 3) ? 4'b0010 : 4'b0000;
      i_wch    = {16'h0, 8'h10 + 8'(b), 8'h0F};
      #1;
      chk("w1_wready", 32'(i_wready1), 32'b0010);
      chk("w1_wch", 32'(o_wch1), 32'(8'h10 + 8'(b)));
      chk("w1_wlast", 32'(o_wlast1), 32'(b == 3));
      chk("w1_ostd", 32'(o_ostd_cnt1), 1);
      tick();
    end
    i_wvalid = '0; i_wlast = '0;
    #1;
    chk("w_done_ostd", 32'(o_ostd_cnt1), 0);
    chk("w_done_wready", 32'(i_wready1), 0);
    tick();
    chk("sb_drained2", sb.size(), 0);

    // ---- priority: master 2 level 3 beats master 0 ----
    do_reset();
    mon_sel = 1'b1;
    o_awready = 1'b1; o_wready = 1'b1;
    i_wvalid = 4'b1111; i_wlast = 4'b1111;
    i_awvalid = 4'b0101;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("pri_grant", 32'(i_awready2), 32'b0100);
      sb.push_back(8'hA2);
      tick();
    end
    i_awvalid = '0;
    #1;
    chk("pri_ostd_steady", 32'(o_ostd_cnt2), 1);
    tick();
    chk("pri_ostd_empty", 32'(o_ostd_cnt2), 0);
    tick();
    chk("sb_drained3", sb.size(), 0);

    // ---- B routing table ----
    do_reset();
    o_bvalid = 1'b1;
    foreach (bv[i]) begin
      o_bch = bv[i].bid; i_bready = bv[i].bready;
      #1;
      chk("b_valid1", 32'(i_bvalid1), 32'(bv[i].exp_bvalid1));
      chk("b_ready1", 32'(o_bready1), 32'(bv[i].exp_bready1));
      chk("b_valid2", 32'(i_bvalid2), 32'(bv[i].exp_bvalid2));
      chk("b_ready2", 32'(o_bready2), 32'(bv[i].exp_bready2));
      chk("b_decerr2", 32'(o_decerr2), 32'(bv[i].exp_decerr2));
      chk("b_bch", 32'(i_bch1), 32'(bv[i].bid));
      tick();
    end
    o_bvalid = 1'b0;
    #1;
    chk("b_idle_valid", 32'(i_bvalid1), 0);
    chk("b_decerr1", 32'(o_decerr1), 0);
    chk("b_decerr2_sticky", 32'(o_decerr2), 1);

    // ---- reset in the middle of a burst ----
    do_reset();
    mon_sel = 1'b0;
    o_wready = 1'b1;
    i_awvalid = 4'b0011;
    tick();
    i_awvalid = 4'b0010; i_wvalid = 4'b0001; i_wch = 32'h77;
    #1;
    chk("mid_wvalid", 32'(o_wvalid1), 1);
    chk("mid_awvalid", 32'(o_awvalid1), 1);
    aresetn = 1'b0;
    #1;
    chk("mid_rst_awvalid", 32'(o_awvalid1), 0);
    chk("mid_rst_wvalid", 32'(o_wvalid1), 0);
    chk("mid_rst_wready", 32'(i_wready1), 0);
    chk("mid_rst_awready", 32'(i_awready1), 0);
    chk("mid_rst_ostd", 32'(o_ostd_cnt1), 0);
    tick();
    i_awvalid = '0; i_wvalid = '0;
    tick();
    aresetn = 1'b1;
    #1;
    chk("post_rst_ostd", 32'(o_ostd_cnt1), 0);
    chk("post_rst_awvalid", 32'(o_awvalid1), 0);
    chk("sb_drained4", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
